// File: rtl/weight_load_seq.sv
// Weight RAM walker: reads NUM_UNITS*WEIGHTS_PER_UNIT words from base_addr and strobes each into the weight mux.
// Optional macro WEIGHT_LOAD_CHECKSUM_EN adds a running modulo-2^DATA_W checksum output of the delivered words.
module weight_load_seq #(
    parameter int NUM_UNITS        = 6,
    parameter int WEIGHTS_PER_UNIT = 1,
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] ram_out,
    output logic [3:0]        unit_sel,
    output logic              write,
    output logic              busy,
    output logic              done
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int                N        = NUM_UNITS * WEIGHTS_PER_UNIT;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam int                WC_W     = (WEIGHTS_PER_UNIT > 1) ? $clog2(WEIGHTS_PER_UNIT) : 1;
    localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(WEIGHTS_PER_UNIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] idx;
    logic [WC_W-1:0]   wcnt;
    logic [3:0]        unit;

    // Outputs are registered on the edge that enters each state, so every
    // strobe lines up exactly with the state it belongs to.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            base      <= '0;
            idx       <= '0;
            wcnt      <= '0;
            unit      <= '0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            ram_out   <= '0;
            unit_sel  <= '0;
            write     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base      <= base_addr;
                        idx       <= '0;
                        wcnt      <= '0;
                        unit      <= '0;
                        ram_rd_en <= 1'b1;
                        ram_addr  <= base_addr;
                        busy      <= 1'b1;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        state     <= READ;
                    end
                end
                READ: begin
                    ram_rd_en <= 1'b0;
                    state     <= LATCH;
                end
                LATCH: begin
                    ram_out  <= ram_data;
                    unit_sel <= unit;
                    write    <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    write    <= 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
                    checksum <= checksum + ram_out;
`endif
                    state    <= GAP;
                end
                GAP: begin
                    idx <= idx + ADDR_W'(1);
                    if (wcnt == WC_LAST) begin
                        wcnt <= '0;
                        unit <= unit + 4'd1;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Address wraps modulo 2^ADDR_W by construction.
                        ram_rd_en <= 1'b1;
                        ram_addr  <= base + idx + ADDR_W'(1);
                        state     <= READ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_write_single: assert property (@(posedge CLOCK) disable iff (RESET) write |=> !write);
    a_rd_wr_excl:   assert property (@(posedge CLOCK) disable iff (RESET) !(write && ram_rd_en));

endmodule

// File: tb/tb_weight_load_seq.sv
// Directed bench for weight_load_seq: default 6x1 instance plus a 3x2 instance sharing one RAM image.
module tb_weight_load_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  base;
    logic        rd_a, rd_b, wr_a, wr_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b, out_a, out_b;
    logic [3:0]  us_a, us_b;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [31:0] cs_a, cs_b;
`endif

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    bit          t_wr [0:40];
    bit          t_rd [0:40];
    bit          t_busy [0:40];
    bit          t_done [0:40];
    logic [7:0]  t_addr [0:40];
    logic [31:0] t_out [0:40];
    logic [3:0]  t_us [0:40];
    logic [31:0] t_cs [0:40];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_a) rdata_a <= mem[addr_a];
        if (rd_b) rdata_b <= mem[addr_b];
    end

    weight_load_seq dut_a (
        .CLOCK(clk), .RESET(rst), .start(start_a), .base_addr(base),
        .ram_rd_en(rd_a), .ram_addr(addr_a), .ram_data(rdata_a),
        .ram_out(out_a), .unit_sel(us_a), .write(wr_a), .busy(busy_a), .done(done_a)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        , .checksum(cs_a)
`endif
    );

    weight_load_seq #(.NUM_UNITS(3), .WEIGHTS_PER_UNIT(2)) dut_b (
        .CLOCK(clk), .RESET(rst), .start(start_b), .base_addr(base),
        .ram_rd_en(rd_b), .ram_addr(addr_b), .ram_data(rdata_b),
        .ram_out(out_b), .unit_sel(us_b), .write(wr_b), .busy(busy_b), .done(done_b)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        , .checksum(cs_b)
`endif
    );

    // Pulse start on one instance, then record its outputs for cycles 1..ncyc
    // (cycle c is sampled at the negedge before edge c). Optional extra start
    // pulses and a reset pulse are driven during the given cycles.
    task automatic run_load(input bit b, input int ncyc, input int rst_c, input int s1, input int s2);
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            t_wr[c]   = b ? wr_b   : wr_a;
            t_rd[c]   = b ? rd_b   : rd_a;
            t_busy[c] = b ? busy_b : busy_a;
            t_done[c] = b ? done_b : done_a;
            t_addr[c] = b ? addr_b : addr_a;
            t_out[c]  = b ? out_b  : out_a;
            t_us[c]   = b ? us_b   : us_a;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
            t_cs[c]   = b ? cs_b   : cs_a;
`else
            t_cs[c]   = '0;
`endif
            if (c == s1 || c == s2) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            rst = (c == rst_c);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if ({rd_a, wr_a, busy_a, done_a} !== 4'b0) begin
            $display("FAIL reset_strobes got %b want 0000", {rd_a, wr_a, busy_a, done_a}); n_bad++;
        end
        n_cmp++;
        if (addr_a !== 8'd0) begin $display("FAIL reset_addr got %0d want 0", addr_a); n_bad++; end
        n_cmp++;
        if (out_a !== 32'd0) begin $display("FAIL reset_out got %0h want 0", out_a); n_bad++; end
        n_cmp++;
        if (us_a !== 4'd0) begin $display("FAIL reset_unit got %0d want 0", us_a); n_bad++; end
        n_cmp++;
        if ({rd_b, wr_b, busy_b, done_b} !== 4'b0) begin
            $display("FAIL reset_b_strobes got %b want 0000", {rd_b, wr_b, busy_b, done_b}); n_bad++;
        end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        bit ew, er;
        int j;
        for (int i = 0; i < 6; i++) mem[i] = 32'd1 << i;
        base = 8'd0;
        run_load(1'b0, 27, -1, -1, -1);
        for (int c = 1; c <= 27; c++) begin
            ew = (c >= 3 && c <= 23 && (c - 3) % 4 == 0);
            er = (c <= 21 && c % 4 == 1);
            if (t_wr[c] !== ew) begin $display("FAIL basic_write c=%0d got %b want %b", c, t_wr[c], ew); n_bad++; end
            n_cmp++;
            if (t_rd[c] !== er) begin $display("FAIL basic_rd c=%0d got %b want %b", c, t_rd[c], er); n_bad++; end
            n_cmp++;
            if (t_busy[c] !== (c <= 24)) begin $display("FAIL basic_busy c=%0d got %b", c, t_busy[c]); n_bad++; end
            n_cmp++;
            if (t_done[c] !== (c == 25)) begin $display("FAIL basic_done c=%0d got %b", c, t_done[c]); n_bad++; end
            n_cmp++;
            if (ew) begin
                j = (c - 3) / 4;
                if (t_us[c] !== 4'(j) || t_out[c] !== (32'd1 << j)) begin
                    $display("FAIL basic_data c=%0d got (%0d,%0d) want (%0d,%0d)", c, t_us[c], t_out[c], j, 32'd1 << j);
                    n_bad++;
                end
                n_cmp++;
            end
            if (er) begin
                if (t_addr[c] !== 8'((c - 1) / 4)) begin
                    $display("FAIL basic_addr c=%0d got %0d want %0d", c, t_addr[c], (c - 1) / 4); n_bad++;
                end
                n_cmp++;
            end
        end
        if (t_out[27] !== 32'd32 || t_us[27] !== 4'd5) begin
            $display("FAIL basic_hold got (%0d,%0d) want (5,32)", t_us[27], t_out[27]); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_wpu2;
        int j;
        for (int i = 10; i < 16; i++) mem[i] = 32'(i);
        base = 8'd10;
        run_load(1'b1, 26, -1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            j = 3 + 4 * k;
            if (t_wr[j] !== 1'b1 || t_us[j] !== 4'(k / 2) || t_out[j] !== 32'(10 + k)) begin
                $display("FAIL wpu2_word%0d got (w=%b,%0d,%0d) want (1,%0d,%0d)", k, t_wr[j], t_us[j], t_out[j], k / 2, 10 + k);
                n_bad++;
            end
            n_cmp++;
        end
        if (t_done[25] !== 1'b1 || t_busy[25] !== 1'b0) begin
            $display("FAIL wpu2_done got done=%b busy=%b want 1,0", t_done[25], t_busy[25]); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_wrap;
        logic [7:0] a;
        for (int k = 0; k < 6; k++) begin
            a = 8'(254 + k);
            mem[a] = 32'hA0 + 32'(k);
        end
        base = 8'd254;
        run_load(1'b0, 26, -1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            a = 8'(254 + k);
            if (t_rd[1 + 4 * k] !== 1'b1 || t_addr[1 + 4 * k] !== a) begin
                $display("FAIL wrap_addr%0d got (rd=%b,%0d) want (1,%0d)", k, t_rd[1 + 4 * k], t_addr[1 + 4 * k], a); n_bad++;
            end
            n_cmp++;
            if (t_out[3 + 4 * k] !== 32'hA0 + 32'(k)) begin
                $display("FAIL wrap_data%0d got %0h want %0h", k, t_out[3 + 4 * k], 32'hA0 + 32'(k)); n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_ignore_start;
        int nw, nd;
        for (int i = 0; i < 6; i++) mem[i] = 32'd1 << i;
        base = 8'd0;
        run_load(1'b0, 30, -1, 5, 25);
        nw = 0;
        nd = 0;
        for (int c = 1; c <= 30; c++) begin
            if (t_wr[c]) nw++;
            if (t_done[c]) nd++;
        end
        if (nw !== 6) begin $display("FAIL ignore_writes got %0d want 6", nw); n_bad++; end
        n_cmp++;
        if (nd !== 1 || t_done[25] !== 1'b1) begin $display("FAIL ignore_done got %0d (c25=%b) want 1", nd, t_done[25]); n_bad++; end
        n_cmp++;
        if (t_wr[7] !== 1'b1 || t_us[7] !== 4'd1 || t_out[7] !== 32'd2) begin
            $display("FAIL ignore_word1 got (w=%b,%0d,%0d) want (1,1,2)", t_wr[7], t_us[7], t_out[7]); n_bad++;
        end
        n_cmp++;
        for (int c = 26; c <= 30; c++) begin
            if (t_busy[c] !== 1'b0 || t_rd[c] !== 1'b0) begin
                $display("FAIL ignore_idle c=%0d got busy=%b rd=%b want 0,0", c, t_busy[c], t_rd[c]); n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid;
        int nw;
        for (int i = 0; i < 6; i++) mem[i] = 32'd1 << i;
        base = 8'd0;
        run_load(1'b0, 20, 9, -1, -1);
        if (t_wr[3] !== 1'b1 || t_rd[9] !== 1'b1) begin
            $display("FAIL rstmid_pre got w3=%b rd9=%b want 1,1", t_wr[3], t_rd[9]); n_bad++;
        end
        n_cmp++;
        for (int c = 10; c <= 20; c++) begin
            if ({t_rd[c], t_wr[c], t_busy[c], t_done[c]} !== 4'b0 || t_addr[c] !== 8'd0 ||
                t_out[c] !== 32'd0 || t_us[c] !== 4'd0) begin
                $display("FAIL rstmid_zero c=%0d got rd=%b w=%b busy=%b done=%b addr=%0d out=%0d unit=%0d",
                         c, t_rd[c], t_wr[c], t_busy[c], t_done[c], t_addr[c], t_out[c], t_us[c]);
                n_bad++;
            end
            n_cmp++;
        end
        run_load(1'b0, 27, -1, -1, -1);
        nw = 0;
        for (int c = 1; c <= 27; c++) if (t_wr[c]) nw++;
        if (nw !== 6 || t_done[25] !== 1'b1) begin
            $display("FAIL rstmid_reload got writes=%0d done25=%b want 6,1", nw, t_done[25]); n_bad++;
        end
        n_cmp++;
        if (t_wr[23] !== 1'b1 || t_us[23] !== 4'd5 || t_out[23] !== 32'd32) begin
            $display("FAIL rstmid_last got (w=%b,%0d,%0d) want (1,5,32)", t_wr[23], t_us[23], t_out[23]); n_bad++;
        end
        n_cmp++;
    endtask

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    task automatic test_checksum;
        for (int i = 0; i < 6; i++) mem[i] = 32'd1 << i;
        base = 8'd0;
        run_load(1'b0, 26, -1, -1, -1);
        if (t_cs[25] !== 32'd63) begin $display("FAIL csum_first got %0d want 63", t_cs[25]); n_bad++; end
        n_cmp++;
        for (int i = 0; i < 6; i++) mem[i] = 32'hFFFF_FFFF;
        run_load(1'b0, 26, -1, -1, -1);
        if (t_cs[1] !== 32'd0) begin $display("FAIL csum_clear got %0h want 0", t_cs[1]); n_bad++; end
        n_cmp++;
        if (t_cs[25] !== 32'hFFFF_FFFA) begin $display("FAIL csum_ones got %0h want fffffffa", t_cs[25]); n_bad++; end
        n_cmp++;
    endtask
`endif

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        base    = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset;
        test_basic;
        test_wpu2;
        test_wrap;
        test_ignore_start;
        test_reset_mid;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        test_checksum;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
